// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receive path.
//   ps2_rx_state_t  frame receiver FSM states
//   PS2_BREAK       key-release prefix byte
//   PS2_EXTENDED    extended-key prefix byte
//   PS2_FRAME_BITS  start + 8 data + parity + stop
//   odd_parity_ok() 1 when {byte, parity} holds an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_t;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXTENDED   = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  function automatic logic odd_parity_ok(input logic [7:0] b, input logic par);
    return ^{b, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions the raw PS/2 clock pin.
//   A 2-FF synchroniser feeds a run-length filter: the filtered level only
//   follows the synced input after FILTER_LEN consecutive samples that all
//   disagree with the current level. Falling transitions of the filtered
//   level produce a registered one-cycle strobe.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset (filtered level returns to idle-high)
//   din  in  raw asynchronous pin, idle high
//   fe   out one-cycle strobe, filtered level went 1 -> 0
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fe
);

  localparam int             CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] run_cnt;
  logic             level;
  logic             level_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= 1'b1;
      sync_p1  <= 1'b1;
      run_cnt  <= '0;
      level    <= 1'b1;
      level_p2 <= 1'b1;
      fe       <= 1'b0;
    end else begin
      // stage p0/p1: metastability guard on the asynchronous pin
      sync_p0 <= din;
      sync_p1 <= sync_p0;

      // filter stage: any sample agreeing with the current level restarts
      // the run, so an isolated glitch shorter than FILTER_LEN never flips it
      if (sync_p1 == level) begin
        run_cnt <= '0;
      end else if (run_cnt == CNT_LAST) begin
        run_cnt <= '0;
        level   <= sync_p1;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end

      // edge stage: previous level vs current level
      level_p2 <= level;
      fe       <= level_p2 & ~level;
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 device-to-host frame receiver.
//   Deserialises start/D0..D7/odd-parity/stop frames clocked by the
//   keyboard, keeps the last two accepted bytes as a 16-bit keycode and
//   flags discarded frames. Break (F0) and extended (E0) prefixes are not
//   interpreted; they are shifted in like any other byte.
// Parameters:
//   FILTER_LEN      consecutive equal samples before filtered ps2_clk changes
//   TIMEOUT_CYCLES  clk cycles without a falling edge mid-frame before abort
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   ps2_clk   in   raw PS/2 clock pin, idle high
//   ps2_data  in   raw PS/2 data pin, idle high
//   keycode   out  [15:8] previous accepted byte, [7:0] latest accepted byte
//   ready     out  one-cycle pulse, keycode updated this cycle
//   rx_err    out  one-cycle pulse, frame discarded (framing, parity, timeout)
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        ready,
  output logic        rx_err
);

  localparam int               DATA_BITS = PS2_FRAME_BITS - 3;
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);
  localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  // Holds at the terminal count so a stalled frame can never wrap back
  // below the abort threshold.
  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (v == TMO_LAST) ? v : v + 1'b1;
  endfunction

  logic          fe;
  logic          data_p0;
  logic          data_p1;

  ps2_rx_state_t state,     state_nxt;
  logic [2:0]    bit_cnt,   bit_cnt_nxt;
  logic [7:0]    shift_reg, shift_nxt;
  logic          par_ok,    par_ok_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic          accept;
  logic          err;

  // stage p0/p1: clock conditioning and data synchroniser
  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filt (
    .clk (clk),
    .rst (rst),
    .din (ps2_clk),
    .fe  (fe)
  );

  // Data is only looked at on fe, long after the line settled mid-high, so
  // a plain synchroniser is enough here.
  always_ff @(posedge clk) begin
    data_p0 <= ps2_data;
    data_p1 <= data_p0;
  end

  // stage p2: frame FSM decisions taken in the fe cycle
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    par_ok_nxt  = par_ok;
    tmo_nxt     = tmo_cnt;
    accept      = 1'b0;
    err         = 1'b0;

    if (state == IDLE || fe) begin
      tmo_nxt = '0;
    end else begin
      tmo_nxt = sat_inc(tmo_cnt);
    end

    case (state)
      IDLE: begin
        // A high data bit on fe is line noise or a lost frame tail, not a
        // start bit; it is ignored silently.
        if (fe && !data_p1) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (fe) begin
          shift_nxt[bit_cnt] = data_p1;
          bit_cnt_nxt        = bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = PARITY;
          end
        end
      end
      PARITY: begin
        if (fe) begin
          par_ok_nxt = odd_parity_ok(shift_reg, data_p1);
          state_nxt  = STOP;
        end
      end
      STOP: begin
        if (fe) begin
          state_nxt = IDLE;
          if (data_p1 && par_ok) begin
            accept = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A coincident fe has already been handled above and takes priority.
    if (state != IDLE && !fe && tmo_cnt == TMO_LAST) begin
      state_nxt = IDLE;
      err       = 1'b1;
    end
  end

  // stage p3: architectural state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_ok    <= 1'b0;
      tmo_cnt   <= '0;
      keycode   <= '0;
      ready     <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      par_ok    <= par_ok_nxt;
      tmo_cnt   <= tmo_nxt;
      ready     <= accept;
      rx_err    <= err;
      if (accept) begin
        keycode <= {keycode[7:0], shift_reg};
      end
    end
  end

endmodule
